// File: rtl/inst_mem_param_if.sv
// Fetch/response/program-load bundle for inst_mem_param.
// master = fetch unit and loader, slave = the instruction store.
interface inst_mem_param_if #(
    parameter int unsigned ADDR_W = 64
) ();
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;

    logic              resp_valid;
    logic              resp_ready;
    logic [31:0]       resp_inst;
    logic [ADDR_W-1:0] resp_pc;
    logic [1:0]        resp_fault;

    logic              flush;

    logic              load_en;
    logic [ADDR_W-1:0] load_addr;
    logic [31:0]       load_data;
    logic              load_err;

    modport master (
        output req_valid, req_addr, resp_ready, flush, load_en, load_addr, load_data,
        input  req_ready, resp_valid, resp_inst, resp_pc, resp_fault, load_err
    );

    modport slave (
        input  req_valid, req_addr, resp_ready, flush, load_en, load_addr, load_data,
        output req_ready, resp_valid, resp_inst, resp_pc, resp_fault, load_err
    );
endinterface

// File: rtl/inst_mem_param.sv
// Byte-addressed instruction store with one-cycle fetch, 2-entry response FIFO,
// fault classification and a word-wide program-load port.
module inst_mem_param #(
    parameter int unsigned DEPTH_BYTES = 256,
    parameter int unsigned ADDR_W      = 64,
    parameter logic [31:0] NOP_INST    = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            reset,
    inst_mem_param_if.slave bus
);
    localparam int unsigned       IDX_W     = (DEPTH_BYTES > 1) ? $clog2(DEPTH_BYTES) : 1;
    localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(DEPTH_BYTES - 4);

    typedef enum logic [1:0] {
        FAULT_OK       = 2'b00,
        FAULT_MISALIGN = 2'b01,
        FAULT_RANGE    = 2'b10
    } fault_e;

    typedef struct packed {
        logic [31:0]       inst;
        logic [ADDR_W-1:0] pc;
        fault_e            fault;
    } resp_t;

    // Misalignment wins over range; range uses the full address width.
    function automatic fault_e classify(input logic [ADDR_W-1:0] addr);
        fault_e f;
        f = FAULT_OK;
        if (addr[1:0] != 2'b00) begin
            f = FAULT_MISALIGN;
        end else if (addr > LAST_WORD) begin
            f = FAULT_RANGE;
        end
        return f;
    endfunction

    logic [7:0]       mem [DEPTH_BYTES];

    fault_e           req_fault;
    fault_e           load_fault;
    logic [IDX_W-1:0] fetch_idx;
    logic [IDX_W-1:0] load_idx;
    logic [31:0]      fetch_word;

    logic             st_valid;
    resp_t            st_entry;
    resp_t            fifo [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       count;
    logic [1:0]       occupancy;
    logic             pop;
    logic             accept;
    logic             load_err_q;
    resp_t            head;

    always_comb begin
        req_fault  = classify(bus.req_addr);
        load_fault = classify(bus.load_addr);
        // Faulted fetches never index the array with the raw address.
        fetch_idx  = (req_fault == FAULT_OK) ? bus.req_addr[IDX_W-1:0] : '0;
        load_idx   = bus.load_addr[IDX_W-1:0];
        fetch_word = {mem[fetch_idx + IDX_W'(3)], mem[fetch_idx + IDX_W'(2)],
                      mem[fetch_idx + IDX_W'(1)], mem[fetch_idx]};
    end

    // Occupancy counts the read in flight so a full pipe still admits one
    // request whenever the head is leaving on the same edge.
    always_comb begin
        head          = fifo[rd_ptr];
        occupancy     = count + 2'(st_valid);
        pop           = (count != 2'd0) && bus.resp_ready;
        bus.req_ready = reset && !bus.load_en && !bus.flush &&
                        ((occupancy < 2'd2) || pop);
        accept        = bus.req_valid && bus.req_ready;
    end

    assign bus.resp_valid = (count != 2'd0);
    assign bus.resp_inst  = bus.resp_valid ? head.inst  : '0;
    assign bus.resp_pc    = bus.resp_valid ? head.pc    : '0;
    assign bus.resp_fault = bus.resp_valid ? head.fault : FAULT_OK;
    assign bus.load_err   = load_err_q;

    always_ff @(posedge clk) begin
        if (reset && bus.load_en && (load_fault == FAULT_OK)) begin
            mem[load_idx]              <= bus.load_data[7:0];
            mem[load_idx + IDX_W'(1)]  <= bus.load_data[15:8];
            mem[load_idx + IDX_W'(2)]  <= bus.load_data[23:16];
            mem[load_idx + IDX_W'(3)]  <= bus.load_data[31:24];
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            st_entry.inst  <= (req_fault == FAULT_OK) ? fetch_word : NOP_INST;
            st_entry.pc    <= bus.req_addr;
            st_entry.fault <= req_fault;
        end
        if (st_valid) begin
            fifo[wr_ptr] <= st_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            st_valid   <= 1'b0;
            count      <= '0;
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            load_err_q <= bus.load_en && (load_fault != FAULT_OK);
            if (bus.flush) begin
                st_valid <= 1'b0;
                count    <= '0;
                wr_ptr   <= 1'b0;
                rd_ptr   <= 1'b0;
            end else begin
                st_valid <= accept;
                if (st_valid) begin
                    wr_ptr <= ~wr_ptr;
                end
                if (pop) begin
                    rd_ptr <= ~rd_ptr;
                end
                count <= count + 2'(st_valid) - 2'(pop);
            end
        end
    end

    a_no_overflow : assert property (@(posedge clk) disable iff (!reset || bus.flush)
        !(st_valid && !pop && (count == 2'd2)));

endmodule

// File: tb/tb_inst_mem_param.sv
// Scoreboarded bench for inst_mem_param: stimulus pushes expected responses,
// a negedge monitor compares every cycle against a byte-array reference model.
module tb_inst_mem_param;
    localparam int unsigned DEPTH  = 256;
    localparam int unsigned ADDR_W = 64;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic clk = 1'b0;
    logic reset = 1'b0;

    inst_mem_param_if #(.ADDR_W(ADDR_W)) bus ();

    inst_mem_param #(
        .DEPTH_BYTES(DEPTH),
        .ADDR_W     (ADDR_W),
        .NOP_INST   (NOP)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] inst;
        logic [63:0] pc;
        logic [1:0]  fault;
        int          avail;
    } exp_t;

    exp_t       q[$];
    logic [7:0] ref_mem [DEPTH];
    int         checks   = 0;
    int         failures = 0;
    int         cyc      = 0;
    bit         exp_lerr = 1'b0;
    bit         rst_prev = 1'b1;

    function automatic logic [1:0] ref_fault(input logic [63:0] a);
        if ((a % 64'd4) != 64'd0) return 2'b01;
        if (a > 64'(DEPTH - 4)) return 2'b10;
        return 2'b00;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        bit   exp_valid;
        bit   exp_ready;
        exp_t e;
        logic [63:0] a;

        exp_valid = (q.size() > 0) && (q[0].avail <= cyc);
        exp_ready = reset && !bus.load_en && !bus.flush &&
                    ((q.size() < 2) || (exp_valid && bus.resp_ready));

        if (cyc >= 1) begin
            chk("resp_valid", 64'(bus.resp_valid), 64'(exp_valid));
            chk("req_ready", 64'(bus.req_ready), 64'(exp_ready));
            chk("load_err", 64'(bus.load_err), 64'(exp_lerr));
            if (exp_valid) begin
                chk("resp_inst", 64'(bus.resp_inst), 64'(q[0].inst));
                chk("resp_pc", bus.resp_pc, q[0].pc);
                chk("resp_fault", 64'(bus.resp_fault), 64'(q[0].fault));
            end
            if (rst_prev) begin
                chk("reset_inst", 64'(bus.resp_inst), 64'd0);
                chk("reset_pc", bus.resp_pc, 64'd0);
                chk("reset_fault", 64'(bus.resp_fault), 64'd0);
            end
        end

        // Reference model update for the coming rising edge.
        exp_lerr = reset && bus.load_en && (ref_fault(bus.load_addr) != 2'b00);
        if (reset && bus.load_en && (ref_fault(bus.load_addr) == 2'b00)) begin
            a = bus.load_addr;
            for (int unsigned b = 0; b < 4; b++) ref_mem[a + 64'(b)] = bus.load_data[8*b +: 8];
        end
        if (!reset || bus.flush) begin
            q.delete();
        end else begin
            if (exp_valid && bus.resp_ready) void'(q.pop_front());
            if (bus.req_valid && exp_ready) begin
                a       = bus.req_addr;
                e.pc    = a;
                e.fault = ref_fault(a);
                e.inst  = (e.fault == 2'b00) ?
                          {ref_mem[a + 3], ref_mem[a + 2], ref_mem[a + 1], ref_mem[a]} : NOP;
                e.avail = cyc + 2;
                q.push_back(e);
            end
        end
        rst_prev = !reset;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [63:0] a, input logic [31:0] d);
        bus.load_en   = 1'b1;
        bus.load_addr = a;
        bus.load_data = d;
        step();
        bus.load_en = 1'b0;
    endtask

    // Hold a request until it is accepted; leaves req_valid high for chaining.
    task automatic issue(input logic [63:0] a);
        bit ok;
        ok = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_addr  = a;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.req_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL issue_timeout addr %0h: req_ready stayed 0, required 1", a);
        end
        step();
    endtask

    task automatic idle(input int n);
        bus.req_valid = 1'b0;
        repeat (n) step();
    endtask

    initial begin
        logic [63:0] fault_addrs [5];
        bus.req_valid  = 1'b0;
        bus.req_addr   = '0;
        bus.resp_ready = 1'b1;
        bus.flush      = 1'b0;
        bus.load_en    = 1'b0;
        bus.load_addr  = '0;
        bus.load_data  = '0;
        repeat (3) step();
        reset = 1'b1;

        for (int unsigned i = 0; i < DEPTH / 4; i++) load(64'(i * 4), $urandom());

        // Load then fetch address 0.
        load(64'h0, 32'h00A0_0F93);
        issue(64'h0);
        idle(3);

        // Back-to-back fetches at full throughput.
        issue(64'h0); issue(64'h4); issue(64'h8); issue(64'hC);
        idle(4);

        // Backpressure: two accepted, third waits for the head to drain.
        bus.resp_ready = 1'b0;
        issue(64'h0); issue(64'h4);
        bus.req_valid = 1'b1;
        bus.req_addr  = 64'h8;
        step(); step();
        bus.resp_ready = 1'b1;
        issue(64'h8);
        idle(4);

        // Fault classification boundaries.
        fault_addrs = '{64'h2, 64'hFD, 64'hFC, 64'h100, 64'hFFFF_FFFF_FFFF_FFFC};
        foreach (fault_addrs[i]) issue(fault_addrs[i]);
        idle(4);

        // Rejected loads, then load colliding with a fetch request.
        load(64'h101, 32'hDEAD_BEEF);
        load(64'h5, 32'hCAFE_F00D);
        issue(64'hFC); issue(64'h4);
        bus.req_valid = 1'b1;
        bus.req_addr  = 64'h20;
        load(64'h20, 32'h1234_5678);
        issue(64'h20);
        idle(3);

        // Flush with two responses pending, also combined with a load.
        bus.resp_ready = 1'b0;
        issue(64'h10); issue(64'h14);
        idle(2);
        bus.flush = 1'b1;
        load(64'h30, 32'hA5A5_5A5A);
        bus.flush = 1'b0;
        step();
        bus.resp_ready = 1'b1;
        issue(64'h30);
        idle(3);

        // Reset with a response pending; memory must survive.
        bus.resp_ready = 1'b0;
        issue(64'h40);
        idle(2);
        reset = 1'b0;
        step(); step();
        reset = 1'b1;
        bus.resp_ready = 1'b1;
        issue(64'h40); issue(64'h0); issue(64'h20);
        idle(3);

        // Randomized traffic.
        for (int n = 0; n < 800; n++) begin
            int unsigned r;
            r = $urandom_range(0, 9);
            case (r)
                0, 1, 2, 3, 4, 5: bus.req_addr = 64'($urandom_range(0, 63) * 4);
                6:                bus.req_addr = 64'($urandom_range(0, 255) | 1);
                7:                bus.req_addr = 64'(256 + $urandom_range(0, 15) * 4);
                8:                bus.req_addr = {$urandom(), $urandom()} & ~64'h3;
                default:          bus.req_addr = 64'hFC;
            endcase
            bus.req_valid  = ($urandom_range(0, 9) < 7);
            bus.resp_ready = ($urandom_range(0, 9) < 7);
            bus.load_en    = ($urandom_range(0, 11) == 0);
            bus.load_addr  = ($urandom_range(0, 4) == 0) ? 64'($urandom_range(0, 300))
                                                         : 64'($urandom_range(0, 63) * 4);
            bus.load_data  = $urandom();
            bus.flush      = ($urandom_range(0, 29) == 0);
            reset          = ($urandom_range(0, 199) != 0);
            step();
        end

        bus.req_valid  = 1'b0;
        bus.load_en    = 1'b0;
        bus.flush      = 1'b0;
        bus.resp_ready = 1'b1;
        reset          = 1'b1;
        for (int i = 0; i < 20 && q.size() != 0; i++) step();
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d responses still expected, required 0", q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/inst_mem_param.md
INST_MEM_PARAM -- requirements
Module: inst_mem_param

Interface
REQ-001 The block SHALL have these parameters:
- DEPTH_BYTES, default 256, byte capacity of the instruction store; a multiple of 4.
- ADDR_W, default 64, width of all address ports.
- NOP_INST, default 32'h00000013, instruction word returned on a faulted fetch.

REQ-002 The block SHALL have these ports:
- clk  in  1  rising-edge clock; the only clock.
- reset  in  1  synchronous, active-low reset.
- req_valid  in  1  fetch request valid.
- req_ready  out  1  fetch request accepted when high with req_valid.
- req_addr  in  ADDR_W  fetch byte address.
- resp_valid  out  1  response available.
- resp_ready  in  1  consumer takes the response.
- resp_inst  out  32  fetched instruction word.
- resp_pc  out  ADDR_W  address that produced the response.
- resp_fault  out  2  fault code: 00 ok, 01 misaligned, 10 out of range.
- flush  in  1  discard all pending responses.
- load_en  in  1  program-load word write enable.
- load_addr  in  ADDR_W  program-load byte address.
- load_data  in  32  program-load word.
- load_err  out  1  one-cycle pulse when a load write is rejected.

Function
REQ-003 Storage SHALL be a DEPTH_BYTES array of 8-bit bytes, assembled little-endian: inst = {mem[a+3], mem[a+2], mem[a+1], mem[a]}.
REQ-004 A fetch SHALL be accepted on any rising edge where req_valid and req_ready are both high.
REQ-005 Read latency SHALL be one cycle: a fetch accepted at edge N is eligible to appear on resp_* after edge N+1.
REQ-006 Responses SHALL be held in a 2-entry FIFO and presented in acceptance order.
- resp_* reflect the FIFO head.
- resp_valid = FIFO non-empty.
REQ-007 The head SHALL pop on an edge where resp_valid and resp_ready are both high; while resp_ready is low, resp_* SHALL hold stable.
REQ-008 Occupancy is defined as FIFO entries plus in-flight reads. req_ready SHALL equal: not load_en, AND not flush, AND (occupancy < 2 OR a pop occurs this cycle).
REQ-009 With resp_ready held high and req_valid continuous, the block SHALL sustain one response per cycle.
REQ-010 Fault classification SHALL be computed at acceptance:
- misaligned if req_addr[1:0] != 0;
- else out of range if req_addr > DEPTH_BYTES-4 (full ADDR_W compare, no truncation or wrap);
- misaligned takes priority over out of range.
REQ-011 A faulted fetch SHALL still produce a response, with resp_inst = NOP_INST, resp_pc = req_addr, and the fault code; the memory SHALL NOT be indexed out of bounds.
REQ-012 A load write with load_en high SHALL write the four bytes of load_data little-endian at load_addr on that edge.
REQ-013 A fetch accepted on the edge after a write SHALL return the new data.
REQ-014 A load write with misaligned or out-of-range load_addr SHALL leave memory unchanged and assert load_err for exactly one cycle on the following cycle.
REQ-015 load_en SHALL take priority over fetch: req_ready SHALL be 0 while load_en is high. Responses already pending SHALL still drain.
REQ-016 On an edge with flush high, the FIFO and all in-flight reads SHALL be discarded; resp_valid SHALL be 0 on the next cycle. No request is accepted in a flush cycle.
REQ-017 Flush and load_en asserted together SHALL both take effect.
REQ-018 The FIFO SHALL never overflow or underflow; the pointers wrap modulo 2.

Reset
REQ-019 While reset is low at an edge, the block SHALL clear the FIFO, in-flight state, and pointers, and SHALL drive:
- resp_valid = 0;
- resp_inst = 0;
- resp_pc = 0;
- resp_fault = 00;
- load_err = 0.
REQ-020 req_ready SHALL be 0 during reset and SHALL reach 1 on the first cycle after reset deasserts.
REQ-021 Reset SHALL NOT alter memory contents.
REQ-022 A reset asserted mid-stream SHALL drop all pending responses with no spurious resp_valid.

Verification
REQ-023 The bench SHALL cover at least these directed scenarios:
- Load 32'h00A00F93 at address 0, then fetch 0 -> resp_inst = 32'h00A00F93, resp_pc = 0, fault 00, one cycle after acceptance.
- Back-to-back fetches 0, 4, 8, 12 with resp_ready = 1 -> four responses on consecutive cycles, in order, req_ready never low.
- resp_ready = 0 and fetches of 0, 4, 8 -> two accepted, req_ready = 0 on the third; raise resp_ready -> 0, then 4, then 8 delivered.
- Fetch 0x2 -> fault 01, resp_inst = 32'h00000013. Fetch 0xFD (DEPTH_BYTES = 256) -> fault 01. Fetch 0xFC -> fault 00. Fetch 0x100 -> fault 10. Fetch 0xFFFF_FFFF_FFFF_FFFC -> fault 10.
- Load to 0x101 -> load_err pulses one cycle and memory is unchanged. Load asserted with req_valid high -> req_ready = 0 that cycle.
- Two responses pending, then flush -> resp_valid = 0 next cycle. Reset with one response pending -> all outputs 0 and memory contents preserved.
